// File: rtl/eth_phy_prbs_test_ctrl_pkg.sv
// Shared definitions for the 10G PHY PRBS31 self-test sequencer.
// Covers the state encoding, the fail codes and the per-state output decode.
package eth_phy_test_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RESET     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_SETTLE    = 3'd3;
  localparam logic [2:0] ST_TEST      = 3'd4;
  localparam logic [2:0] ST_PASS      = 3'd5;
  localparam logic [2:0] ST_FAIL      = 3'd6;
  localparam logic [2:0] ST_RECHECK   = 3'd7;

  localparam logic [1:0] FC_NONE            = 2'd0;
  localparam logic [1:0] FC_LOCK_TIMEOUT    = 2'd1;
  localparam logic [1:0] FC_ERR_THRESH      = 2'd2;
  localparam logic [1:0] FC_RECHECK_TIMEOUT = 2'd3;

  function automatic logic st_phy_rst(input logic [2:0] s);
    return (s == ST_IDLE) || (s == ST_RESET);
  endfunction

  function automatic logic st_prbs_en(input logic [2:0] s);
    return (s == ST_SETTLE) || (s == ST_TEST);
  endfunction

  function automatic logic st_busy(input logic [2:0] s);
    return (s == ST_RESET) || (s == ST_WAIT_LOCK) || (s == ST_SETTLE) ||
           (s == ST_TEST) || (s == ST_RECHECK);
  endfunction

  function automatic logic st_done(input logic [2:0] s);
    return (s == ST_PASS) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/eth_phy_prbs_test_ctrl_if.sv
// Signals between the PRBS test sequencer (master) and the 10G PHY (slave).
// All signals are plain levels sampled every clock; there is no valid/ready handshake on this link.
interface eth_phy_prbs_test_ctrl_if;
  logic       rx_block_lock;
  logic [6:0] rx_error_count;
  logic       phy_rst;
  logic       cfg_tx_prbs31_enable;
  logic       cfg_rx_prbs31_enable;

  modport master (
    input  rx_block_lock,
    input  rx_error_count,
    output phy_rst,
    output cfg_tx_prbs31_enable,
    output cfg_rx_prbs31_enable
  );

  modport slave (
    output rx_block_lock,
    output rx_error_count,
    input  phy_rst,
    input  cfg_tx_prbs31_enable,
    input  cfg_rx_prbs31_enable
  );
endinterface

// File: rtl/eth_phy_prbs_test_ctrl_err_acc.sv
// Saturating PRBS error accumulator with synchronous clear and enable.
// The exceed flag looks at the value that will be stored this cycle, so the crossing cycle counts.
module eth_prbs_err_acc #(
  parameter int unsigned           ERR_WIDTH = 32,
  parameter logic [ERR_WIDTH-1:0]  THRESH    = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [6:0]           inc,
  output logic [ERR_WIDTH-1:0] total,
  output logic                 exceed
);

  localparam int unsigned SUM_W = ((ERR_WIDTH > 7) ? ERR_WIDTH : 7) + 1;
  localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'({ERR_WIDTH{1'b1}});

  logic [SUM_W-1:0]     sum;
  logic [ERR_WIDTH-1:0] sum_sat;
  logic [ERR_WIDTH-1:0] total_d;
  logic [ERR_WIDTH-1:0] total_q;

  always_comb begin
    sum     = SUM_W'(total_q) + SUM_W'(inc);
    sum_sat = (sum > MAX_EXT) ? {ERR_WIDTH{1'b1}} : sum[ERR_WIDTH-1:0];
    exceed  = en && (sum_sat > THRESH);
    total_d = total_q;
    if (clr) begin
      total_d = '0;
    end else if (en) begin
      total_d = sum_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;

endmodule

// File: rtl/eth_phy_prbs_test_ctrl.sv
// PRBS31 self-test sequencer for eth_phy_10g: reset, lock wait, settle, error window, verdict.
// Optional ETH_PRBS_LOCK_RECHECK_EN adds a post-window block-lock recheck before PASS.
module eth_phy_prbs_test_ctrl
  import eth_phy_test_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned TEST_CYCLES   = 65536,
  parameter int unsigned ERR_THRESH    = 0,
  parameter int unsigned ERR_WIDTH     = 32,
  parameter int unsigned TMR_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  eth_phy_prbs_test_ctrl_if.master        phy,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [1:0]                      fail_code,
  output logic [ERR_WIDTH-1:0]            err_total,
  output logic [2:0]                      state_o
);

  localparam logic [TMR_WIDTH-1:0] RST_LOAD    = TMR_WIDTH'(RESET_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] LOCK_LOAD   = TMR_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_WIDTH-1:0] SETTLE_LOAD = TMR_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] TEST_LOAD   = TMR_WIDTH'(TEST_CYCLES - 1);
  localparam logic [ERR_WIDTH-1:0] THRESH_W    = ERR_WIDTH'(ERR_THRESH);

  logic [2:0]           state_q, state_d;
  logic [TMR_WIDTH-1:0] timer_q, timer_d;
  logic [1:0]           fail_code_q, fail_code_d;
  logic                 phy_rst_q, prbs_en_q, busy_q, done_q, pass_q;
  logic                 tmr_zero;
  logic                 acc_clr, acc_en, acc_exceed;

  eth_prbs_err_acc #(
    .ERR_WIDTH (ERR_WIDTH),
    .THRESH    (THRESH_W)
  ) u_err_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .en     (acc_en),
    .inc    (phy.rx_error_count),
    .total  (err_total),
    .exceed (acc_exceed)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    fail_code_d = fail_code_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    tmr_zero    = (timer_q == '0);
    // abort outranks start and every timed transition, and freezes the error total
    if (abort) begin
      state_d     = ST_IDLE;
      fail_code_d = FC_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            state_d     = ST_RESET;
            timer_d     = RST_LOAD;
            fail_code_d = FC_NONE;
            acc_clr     = 1'b1;
          end
        end
        ST_RESET: begin
          if (tmr_zero) begin
            state_d = ST_WAIT_LOCK;
            timer_d = LOCK_LOAD;
          end else begin
            timer_d = timer_q - TMR_WIDTH'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (phy.rx_block_lock) begin
            state_d = ST_SETTLE;
            timer_d = SETTLE_LOAD;
          end else if (tmr_zero) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_LOCK_TIMEOUT;
          end else begin
            timer_d = timer_q - TMR_WIDTH'(1);
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state_d = ST_TEST;
            timer_d = TEST_LOAD;
          end else begin
            timer_d = timer_q - TMR_WIDTH'(1);
          end
        end
        ST_TEST: begin
          acc_en = 1'b1;
          // a threshold crossing on the final window cycle still fails
          if (acc_exceed) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_ERR_THRESH;
          end else if (tmr_zero) begin
`ifdef ETH_PRBS_LOCK_RECHECK_EN
            state_d = ST_RECHECK;
            timer_d = LOCK_LOAD;
`else
            state_d = ST_PASS;
`endif
          end else begin
            timer_d = timer_q - TMR_WIDTH'(1);
          end
        end
`ifdef ETH_PRBS_LOCK_RECHECK_EN
        ST_RECHECK: begin
          if (phy.rx_block_lock) begin
            state_d = ST_PASS;
          end else if (tmr_zero) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_RECHECK_TIMEOUT;
          end else begin
            timer_d = timer_q - TMR_WIDTH'(1);
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      fail_code_q <= FC_NONE;
      phy_rst_q   <= 1'b1;
      prbs_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      fail_code_q <= fail_code_d;
      phy_rst_q   <= st_phy_rst(state_d);
      prbs_en_q   <= st_prbs_en(state_d);
      busy_q      <= st_busy(state_d);
      done_q      <= st_done(state_d);
      pass_q      <= (state_d == ST_PASS);
    end
  end

  assign phy.phy_rst              = phy_rst_q;
  assign phy.cfg_tx_prbs31_enable = prbs_en_q;
  assign phy.cfg_rx_prbs31_enable = prbs_en_q;
  assign busy                     = busy_q;
  assign done                     = done_q;
  assign pass                     = pass_q;
  assign fail_code                = fail_code_q;
  assign state_o                  = state_q;

endmodule

// File: doc/eth_phy_prbs_test_ctrl.md
Name: eth_phy_prbs_test_ctrl

Overview:
Sequencer for the 10G PHY PRBS31 self-test. It holds the PHY in reset, waits for normal-mode block lock, then enables TX/RX PRBS31. After a settle window it accumulates the per-cycle rx_error_count over a fixed test window and reports pass/fail with a fail code. It sits beside eth_phy_10g, driving its reset and cfg_*_prbs31_enable pins and consuming its status outputs.

Parameters:
RESET_CYCLES, 16, cycles phy_rst is held in RESET state (>=1)
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before failing (>=1)
SETTLE_CYCLES, 64, cycles with PRBS enabled before counting errors (>=1)
TEST_CYCLES, 65536, length of error-counting window (>=1)
ERR_THRESH, 0, max tolerated accumulated errors; err_total > ERR_THRESH fails
ERR_WIDTH, 32, width of err_total accumulator
TMR_WIDTH, 32, width of shared down-counter; must hold max of the cycle parameters

Ports:
clk  in  1  single clock for the whole block
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a test from IDLE/PASS/FAIL
abort  in  1  single-cycle pulse; returns to IDLE from any state
rx_block_lock  in  1  PHY block lock status
rx_error_count  in  7  PRBS bit errors detected this cycle by PHY
phy_rst  out  1  active-high reset to PHY tx_rst/rx_rst
cfg_tx_prbs31_enable  out  1  PHY TX PRBS31 enable
cfg_rx_prbs31_enable  out  1  PHY RX PRBS31 checker enable
busy  out  1  high in RESET/WAIT_LOCK/SETTLE/TEST(/RECHECK)
done  out  1  high in PASS or FAIL
pass  out  1  high only in PASS
fail_code  out  2  0 none, 1 lock timeout, 2 error threshold, 3 recheck lock timeout
err_total  out  ERR_WIDTH  saturating accumulated error count
state_o  out  3  current state encoding (debug)

Behaviour:
- Reset (rst_n low, async): state IDLE; phy_rst=1; both PRBS enables=0; busy=done=pass=0; fail_code=0; err_total=0; timer=0. Every output is registered.
- IDLE: phy_rst=1. On start -> RESET: timer loaded RESET_CYCLES-1, err_total cleared, fail_code cleared.
- RESET: phy_rst=1. At timer==0 -> WAIT_LOCK, timer=LOCK_TIMEOUT-1, and phy_rst falls.
- WAIT_LOCK: rx_block_lock sampled high -> SETTLE (timer=SETTLE_CYCLES-1), both enables rise next cycle. Timer reaches 0 without lock -> FAIL, fail_code=1.
- SETTLE: enables=1; rx_error_count ignored. At timer==0 -> TEST, timer=TEST_CYCLES-1.
- TEST: enables=1; each cycle err_total += rx_error_count, saturating at all-ones. If the updated total exceeds ERR_THRESH -> FAIL immediately with fail_code=2; the accumulation of that cycle is still included. At timer==0 without exceeding -> PASS. rx_block_lock is ignored while PRBS is enabled.
- PASS/FAIL: enables=0, phy_rst=0. err_total and fail_code are held. start -> RESET, which clears them.
- start is ignored in busy states.
- abort has priority over start and over every transition in the same cycle -> IDLE; enables=0, phy_rst=1, err_total held, fail_code=0.
- A cycle that is both the last TEST cycle and the threshold-crossing cycle resolves to FAIL.
- Timer is a single shared down-counter that decrements only in timed states. Each phase lasts exactly its parameter count of cycles.
- Latency: start at cycle N puts state_o=RESET at N+1. phy_rst deasserts at N+1+RESET_CYCLES.

Optional Feature:
ETH_PRBS_LOCK_RECHECK_EN
- Defined: TEST-complete goes to RECHECK instead of PASS. RECHECK has enables=0 and timer=LOCK_TIMEOUT-1. Lock seen -> PASS; timer at 0 -> FAIL with fail_code=3. busy is high in RECHECK.
- Undefined: the RECHECK state and fail_code 3 are never produced.

Decomposition:
- Shared package eth_phy_test_pkg: state encoding (IDLE=0, RESET=1, WAIT_LOCK=2, SETTLE=3, TEST=4, PASS=5, FAIL=6, RECHECK=7) and fail-code constants.
- One sub-module eth_prbs_err_acc: saturating ERR_WIDTH accumulator with clear, enable, and a threshold-exceeded flag.
- FSM and timer stay in the top module.

Test Plan:
- Lock high, rx_error_count=0, start pulse -> phy_rst low after 16 cycles. Enables high for 64+65536 cycles. PASS with pass=1, fail_code=0, err_total=0.
- Lock never asserted -> FAIL exactly 4096 cycles after entering WAIT_LOCK, fail_code=1, enables never high.
- ERR_THRESH=10, inject rx_error_count=7 on two TEST cycles -> FAIL on the second injection, err_total=14, fail_code=2. Errors injected during SETTLE are not counted.
- ERR_WIDTH=8, ERR_THRESH=255, rx_error_count=127 every TEST cycle -> err_total saturates at 255 and does not fail until the window ends. Window end gives PASS.
- abort and start pulsed together mid-TEST -> IDLE next cycle, enables=0, phy_rst=1. rst_n dropped mid-SETTLE -> all outputs at reset values immediately.
- With ETH_PRBS_LOCK_RECHECK_EN and lock dropped after TEST -> RECHECK then FAIL with fail_code=3. With lock held -> PASS.
